dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM stage's memory port (addr/re/we/wrt_data -> rd_data).
- Accepts one load or store at a time from the MEM stage and completes it after a fixed latency.
- Asserts busy so the pipeline stalls while the access is in flight.
- Owns the word-organised data array and flags misaligned and out-of-range accesses.

Parameters:
- ADDR_W, 16, byte address width from the MEM stage.
- DATA_W, 16, data word width.
- MEM_WORDS, 1024, number of words in the array; word index = addr[ADDR_W-1:1].
- LATENCY, 3, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  byte address; held stable by the requester while busy.
- re  in  1  read request (mem_to_reg).
- we  in  1  write request (reg_to_mem).
- wrt_data  in  DATA_W  store data; held stable while busy.
- rd_data  out  DATA_W  registered load result.
- rd_valid  out  1  one-cycle pulse when rd_data carries a new load result.
- busy  out  1  stall request to the pipeline.
- err  out  1  one-cycle pulse at completion of a misaligned, out-of-range or re&we access.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, busy=0, rd_valid=0, err=0, rd_data=0.
  - The data array is not reset.
  - Reset mid-access abandons the access; a pending write never reaches the array.
- State IDLE:
  - If re|we, latch addr, wrt_data, kind and error flags.
  - busy is asserted combinationally in the same cycle, so the pipeline holds.
  - Next state: ACCESS with cnt=LATENCY-1 when LATENCY>1; DONE when LATENCY=1.
  - If re=we=0: stay in IDLE, busy=0.
- State ACCESS:
  - busy=1; cnt decrements each cycle.
  - When cnt reaches 1, next state is DONE.
  - Inputs are ignored; only latched values are used.
- State DONE (one cycle):
  - busy=0, so the pipeline advances at the end of this cycle.
  - Inputs are ignored even though the same request is still on the port.
  - rd_valid=1 for a read; err=1 if flagged.
  - Next state: IDLE unconditionally.
- Array update and read capture:
  - Both happen on the clock edge that enters DONE.
  - Write: mem[idx] <= latched wrt_data.
  - Read: rd_data <= mem[idx].
- Latency:
  - busy is high for exactly LATENCY cycles per access.
  - Each access occupies LATENCY+1 cycles, including DONE.
  - Back-to-back requests are accepted on the cycle after DONE.
- rd_data holds its value until the next completed read; writes and errors do not change it.
- Misaligned (addr[0]=1): the access uses addr with bit 0 cleared, completes normally, and pulses err.
- Out-of-range (idx >= MEM_WORDS):
  - Write is dropped; read returns 0 with rd_valid=1.
  - err pulses.
- re&we both high:
  - Treated as a write; no rd_valid.
  - err pulses.
- Address arithmetic: idx = addr >> 1, unsigned; no wrap into the array.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n low, then high; no requests for 5 cycles.
  - Required response: busy=0, rd_valid=0, err=0, rd_data=0x0000 throughout.
- Write then read:
  - Stimulus: LATENCY=3; write 0xBEEF @0x0010, then read @0x0010.
  - Required response: busy high 3 cycles for each access; DONE with rd_valid=1, rd_data=0xBEEF, err=0; total 8 cycles.
- LATENCY=1 back-to-back:
  - Stimulus: writes 0x1111 @0x0000 and 0x2222 @0x0002, then reads @0x0000 and @0x0002, each request presented on the cycle after the previous DONE.
  - Required response: busy=1 for one cycle per access; rd_data 0x1111 then 0x2222.
- Misaligned and out-of-range:
  - Stimulus: read @0x0011 after writing 0xBEEF @0x0010; then write 0x5555 @0x0800 with MEM_WORDS=1024; then read @0x0800.
  - Required response: first read gives rd_data=0xBEEF with err pulse; out-of-range write sets err and leaves the array unchanged; read @0x0800 gives rd_data=0x0000, rd_valid=1, err=1.
- Simultaneous re&we:
  - Stimulus: re=we=1, addr 0x0020, wrt_data 0xA5A5.
  - Required response: no rd_valid, err=1 at DONE; a later read @0x0020 returns 0xA5A5.
- Reset mid-access:
  - Stimulus: after a completed write of 0x1234 @0x0030, write 0xFFFF @0x0030; assert rst_n low during its 2nd ACCESS cycle; release; read @0x0030.
  - Required response: busy drops immediately; the read returns 0x1234.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage memory port.
// One access in flight at a time; busy stalls the pipeline until DONE.
module dmem_responder #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wrt_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = ADDR_W - 1;
    localparam int AW    = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_q;
    logic              rd_q;
    logic              oor_q;
    logic              bad_q;
    logic              rd_valid_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic              req;
    logic [IDX_W-1:0]  in_idx;
    logic              in_oor;
    logic              in_bad;
    logic              direct;
    logic              finish_d;
    logic [IDX_W-1:0]  idx_d;
    logic [DATA_W-1:0] wdata_d;
    logic              wr_d;
    logic              rd_d;
    logic              oor_d;
    logic              bad_d;

    assign req    = re | we;
    assign in_idx = addr[ADDR_W-1:1];
    assign in_oor = 32'(in_idx) >= 32'(MEM_WORDS);
    assign in_bad = addr[0] | in_oor | (re & we);

    // With LATENCY=1 the access completes straight from IDLE,
    // before anything is latched, so the live port is used.
    assign direct   = (state_q == IDLE) && req && (LATENCY == 1);
    assign finish_d = direct || ((state_q == ACCESS) && (cnt_q == 4'd1));

    assign idx_d   = direct ? in_idx   : idx_q;
    assign wdata_d = direct ? wrt_data : wdata_q;
    assign wr_d    = direct ? we       : wr_q;
    assign rd_d    = direct ? (re & ~we) : rd_q;
    assign oor_d   = direct ? in_oor   : oor_q;
    assign bad_d   = direct ? in_bad   : bad_q;

    assign busy = rst_n &&
                  (((state_q == IDLE) && req) || (state_q == ACCESS));

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            oor_q      <= 1'b0;
            bad_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= finish_d && rd_d;
            err_q      <= finish_d && bad_d;
            if (finish_d && rd_d) begin
                rd_data_q <= oor_d ? '0 : mem_q[idx_d[AW-1:0]];
            end
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= in_idx;
                        wdata_q <= wrt_data;
                        wr_q    <= we;
                        rd_q    <= re & ~we;
                        oor_q   <= in_oor;
                        bad_q   <= in_bad;
                        if (LATENCY == 1) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Array is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && finish_d && wr_d && !oor_d) begin
            mem_q[idx_d[AW-1:0]] <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=3 and LATENCY=1 instances,
// directed vector table, reset corner cases and a random model check.
module tb_dmem_responder;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        re_r   [2];
    logic        we_r   [2];
    logic [15:0] addr_r [2];
    logic [15:0] wd_r   [2];
    logic [15:0] rd_w   [2];
    logic        rdv_w  [2];
    logic        busy_w [2];
    logic        err_w  [2];

    dmem_responder #(
        .ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(LAT0)
    ) u_l3 (
        .clk(clk), .rst_n(rst_n), .addr(addr_r[0]), .re(re_r[0]),
        .we(we_r[0]), .wrt_data(wd_r[0]), .rd_data(rd_w[0]),
        .rd_valid(rdv_w[0]), .busy(busy_w[0]), .err(err_w[0])
    );

    dmem_responder #(
        .ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(LAT1)
    ) u_l1 (
        .clk(clk), .rst_n(rst_n), .addr(addr_r[1]), .re(re_r[1]),
        .we(we_r[1]), .wrt_data(wd_r[1]), .rd_data(rd_w[1]),
        .rd_valid(rdv_w[1]), .busy(busy_w[1]), .err(err_w[1])
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ref_mem  [2][1024];
    logic [15:0] ref_last [2];

    typedef struct {
        int          s;
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        v;
        logic        e;
        logic [15:0] q;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        for (int s = 0; s < 2; s++) begin
            check({name, "_busy"}, 16'(busy_w[s]), 16'h0);
            check({name, "_rdv"}, 16'(rdv_w[s]), 16'h0);
            check({name, "_err"}, 16'(err_w[s]), 16'h0);
            check({name, "_rd"}, rd_w[s], 16'h0);
        end
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic do_access(input int s, input logic r, input logic w,
                             input logic [15:0] a, input logic [15:0] d,
                             input logic ev, input logic ee,
                             input logic [15:0] eq);
        int n;
        bit done;
        re_r[s] = r;
        we_r[s] = w;
        addr_r[s] = a;
        wd_r[s] = d;
        n = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (busy_w[s]) begin
                n++;
                check("early_pulse", {14'h0, rdv_w[s], err_w[s]}, 16'h0);
            end else begin
                done = 1;
            end
        end
        check("busy_cycles", 16'(n), 16'((s == 0) ? LAT0 : LAT1));
        check("rd_valid", 16'(rdv_w[s]), 16'(ev));
        check("err", 16'(err_w[s]), 16'(ee));
        check("rd_data", rd_w[s], eq);
        @(posedge clk);
        #1;
        re_r[s] = 1'b0;
        we_r[s] = 1'b0;
    endtask

    task automatic model_upd(input int s, input logic r, input logic w,
                             input logic [15:0] a, input logic [15:0] d,
                             output logic ev, output logic ee,
                             output logic [15:0] eq);
        int idx;
        bit oor;
        idx = int'(a) / 2;
        oor = idx >= 1024;
        ev = r & ~w;
        ee = a[0] | oor | (r & w);
        if (w && !oor) ref_mem[s][idx] = d;
        if (ev) ref_last[s] = oor ? 16'h0 : ref_mem[s][idx];
        eq = ref_last[s];
    endtask

    task automatic model_access(input int s, input logic r, input logic w,
                                input logic [15:0] a, input logic [15:0] d);
        logic ev, ee;
        logic [15:0] eq;
        model_upd(s, r, w, a, d, ev, ee, eq);
        do_access(s, r, w, a, d, ev, ee, eq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ev, ee;
        logic [15:0] eq;
        logic [15:0] a;
        logic r, w;
        int k;

        tbl[0]  = '{0, 1'b0, 1'b1, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        tbl[3]  = '{0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        tbl[4]  = '{0, 1'b0, 1'b1, 16'h0800, 16'h5555, 1'b0, 1'b1, 16'hBEEF};
        tbl[5]  = '{0, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1, 16'h0000};
        tbl[6]  = '{0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0F0F};
        tbl[7]  = '{0, 1'b1, 1'b1, 16'h0020, 16'hA5A5, 1'b0, 1'b1, 16'h0F0F};
        tbl[8]  = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'hA5A5};
        tbl[9]  = '{0, 1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, 1'b0, 16'hA5A5};
        tbl[10] = '{1, 1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000};
        tbl[11] = '{1, 1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111};
        tbl[13] = '{1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h2222};

        for (int s = 0; s < 2; s++) begin
            re_r[s] = 1'b0;
            we_r[s] = 1'b0;
            addr_r[s] = 16'h0;
            wd_r[s] = 16'h0;
            ref_last[s] = 16'h0;
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle");
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            model_upd(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                      ev, ee, eq);
            do_access(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                      tbl[i].v, tbl[i].e, tbl[i].q);
        end

        // Abort a pending write during its second ACCESS cycle.
        we_r[0] = 1'b1;
        addr_r[0] = 16'h0030;
        wd_r[0] = 16'hFFFF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_pre_reset", 16'(busy_w[0]), 16'h1);
        rst_n = 1'b0;
        #1;
        check("busy_in_reset", 16'(busy_w[0]), 16'h0);
        we_r[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_last[0] = 16'h0;
        ref_last[1] = 16'h0;
        check("rd_after_reset", rd_w[0], 16'h0);
        do_access(0, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, 16'h1234);
        ref_last[0] = 16'h1234;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                model_access(s, 1'b0, 1'b1, 16'(2 * i), 16'($urandom));
            end
        end

        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) a = 16'(2048 + $urandom_range(0, 63487));
            else a = 16'($urandom_range(0, 127));
            k = int'($urandom_range(0, 4));
            r = (k <= 2);
            w = (k == 0) || (k >= 3);
            model_access(int'($urandom_range(0, 1)), r, w, a,
                         16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
